// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte-wide
// requesters using a valid/ready handshake. The grant is held until tx_done.
// Optional packet lock is enabled by defining UART_TXARB_PKT_LOCK_EN. With the
// lock, the owner of an unfinished packet (req_last=0) keeps the transmitter.
module uart_tx_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int D_W   = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*D_W-1:0] req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [D_W-1:0]       tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [D_W-1:0]   data_q, data_d;
  logic             start_q, start_d;
  logic [N_REQ-1:0] ready_q, ready_d;

  logic [N_REQ-1:0] elig;
  logic             found;
  logic [ID_W-1:0]  sel;

`ifdef UART_TXARB_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  owner_q, owner_d;

  // While a packet is open only its owner may be granted.
  always_comb begin
    elig = req_valid;
    if (lock_q) begin
      elig          = '0;
      elig[owner_q] = req_valid[owner_q];
    end
  end
`else
  // Every requester is eligible; req_last has no meaning without the lock.
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig        = req_valid;
`endif

  // First eligible requester at or above rr_ptr, wrapping (N_REQ is a power of two).
  always_comb begin
    logic [ID_W-1:0] idx;
    idx   = '0;
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr_q + ID_W'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state logic: accept a byte in IDLE, wait for tx_done in BUSY.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    start_d  = 1'b0;
    ready_d  = '0;
`ifdef UART_TXARB_PKT_LOCK_EN
    lock_d   = lock_q;
    owner_d  = owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = BUSY;
          grant_d      = sel;
          data_d       = req_data[int'(sel)*D_W +: D_W];
          start_d      = 1'b1;
          ready_d[sel] = 1'b1;
`ifdef UART_TXARB_PKT_LOCK_EN
          lock_d       = ~req_last[sel];
          owner_d      = sel;
`endif
        end
      end
      BUSY: begin
        // tx_done in the tx_start cycle also completes the current byte.
        if (tx_done) begin
          state_d = IDLE;
`ifdef UART_TXARB_PKT_LOCK_EN
          if (!lock_q) rr_ptr_d = grant_q + ID_W'(1);
`else
          rr_ptr_d = grant_q + ID_W'(1);
`endif
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      ready_q  <= '0;
`ifdef UART_TXARB_PKT_LOCK_EN
      lock_q   <= 1'b0;
      owner_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
`ifdef UART_TXARB_PKT_LOCK_EN
      lock_q   <= lock_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign busy      = (state_q == BUSY);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues feed the DUT, a scoreboard
// holds the expected (grant, byte) order, and a small uart_tx stand-in
// returns tx_done a fixed number of cycles after each tx_start.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N_REQ    = 4;
  localparam int D_W      = 8;
  localparam int DONE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(.N_REQ(N_REQ), .D_W(D_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb[$];
  logic [8:0]  rbuf[4][16];
  int          rhead[4];
  int          rtail[4];
  int          ready_cnt[4];
  int          timer;
  logic        man_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic last);
    rbuf[i][rtail[i]] = {last, d};
    rtail[i]++;
  endtask

  task automatic expect_tx(input int id, input logic [7:0] d);
    sb.push_back({8'(id), d});
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (rhead[i] < rtail[i]);
      req_data[i*8 +: 8] = rbuf[i][rhead[i]][7:0];
      req_last[i]        = rbuf[i][rhead[i]][8];
    end
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < 4; i++) if (rhead[i] < rtail[i]) p = 1'b1;
    return p;
  endfunction

  // One clock: observe outputs 1ns after the edge, then update inputs.
  task automatic step();
    logic [15:0] e;
    logic [3:0]  er;
    logic        fire;
    fire = 1'b0;
    @(posedge clk); #1;
    if (tx_start) begin
      chk("sb_nonempty_at_start", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        er = 4'b0001 << e[9:8];
        chk("sb_grant", grant_id, e[15:8]);
        chk("sb_data", tx_data, e[7:0]);
        chk("sb_ready", req_ready, er);
      end
      timer = DONE_LAT;
    end else begin
      chk("ready_without_start", req_ready, 4'b0000);
      if (timer > 0) begin
        timer--;
        fire = (timer == 0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        ready_cnt[i]++;
        if (rhead[i] < rtail[i]) rhead[i]++;
      end
    end
    tx_done  = fire | man_done;
    man_done = 1'b0;
    drive_reqs();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() > 0 || busy || pending()) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, (n < 300), 1'b1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    timer    = 0;
    man_done = 1'b0;
    step();
    rst      = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    tx_done = 1'b0; man_done = 1'b0; timer = 0;
    for (int i = 0; i < 4; i++) begin
      rhead[i] = 0; rtail[i] = 0; ready_cnt[i] = 0;
      for (int j = 0; j < 16; j++) rbuf[i][j] = '0;
    end
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    repeat (9) step();

    // Single requester: 2 sends 0xA5.
    load(2, 8'hA5, 1'b1); expect_tx(2, 8'hA5); drive_reqs();
    step();
    chk("t1_tx_start", tx_start, 1);
    chk("t1_tx_data", tx_data, 8'hA5);
    chk("t1_grant_id", grant_id, 2);
    chk("t1_req_ready", req_ready, 4'b0100);
    chk("t1_busy", busy, 1);
    n = 0;
    while (!tx_done && n < 20) begin
      step();
      chk("t1_busy_hold", busy, 1);
      n++;
    end
    chk("t1_done_in_time", (n < 20), 1'b1);
    step();
    chk("t1_busy_fall", busy, 0);
    chk("t1_no_restart", tx_start, 0);

    // All requesters simultaneously: strict 0,1,2,3 order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ready_cnt[i] = 0;
      load(i, 8'(8'h10 + i), 1'b1);
      expect_tx(i, 8'(8'h10 + i));
    end
    drive_reqs();
    drain("t2");
    for (int i = 0; i < 4; i++) chk($sformatf("t2_ready_cnt%0d", i), ready_cnt[i], 1);

    // Round-robin pointer: after a grant to 1, 3 goes before 0.
    do_reset();
    load(1, 8'h21, 1'b1); expect_tx(1, 8'h21); drive_reqs();
    drain("t3a");
    load(0, 8'h30, 1'b1); load(3, 8'h33, 1'b1);
    expect_tx(3, 8'h33); expect_tx(0, 8'h30); drive_reqs();
    drain("t3b");

    // Three-byte packet from 0 with 1 valid throughout.
    do_reset();
    load(0, 8'hA0, 1'b0); load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
    load(1, 8'hB0, 1'b1);
`ifdef UART_TXARB_PKT_LOCK_EN
    expect_tx(0, 8'hA0); expect_tx(0, 8'hA1); expect_tx(0, 8'hA2); expect_tx(1, 8'hB0);
`else
    expect_tx(0, 8'hA0); expect_tx(1, 8'hB0); expect_tx(0, 8'hA1); expect_tx(0, 8'hA2);
`endif
    drive_reqs();
    drain("t4");

    // Reset in the middle of a byte; remaining requesters restart from index 0.
    do_reset();
    load(2, 8'hC3, 1'b1); expect_tx(2, 8'hC3); drive_reqs();
    step();
    chk("t5_tx_start", tx_start, 1);
    load(1, 8'h1C, 1'b1); load(3, 8'h3C, 1'b1); drive_reqs();
    step();
    chk("t5_busy_ignores_valid", busy, 1);
    rst = 1'b1; timer = 0;
    step();
    rst = 1'b0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_tx_start", tx_start, 0);
    chk("t5_rst_grant_id", grant_id, 0);
    chk("t5_rst_tx_data", tx_data, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    expect_tx(1, 8'h1C); expect_tx(3, 8'h3C);
    drain("t5");

    // Spurious tx_done while idle.
    man_done = 1'b1;
    step();
    step();
    chk("t6_busy", busy, 0);
    chk("t6_tx_start", tx_start, 0);
    chk("t6_grant_id", grant_id, 3);
    step();
    chk("t6_still_idle", busy, 0);
    load(0, 8'h60, 1'b1); load(1, 8'h61, 1'b1);
    expect_tx(0, 8'h60); expect_tx(1, 8'h61); drive_reqs();
    drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
